multiplexor_n_in_arb: RTL

//  N-input, NB_DATA-wide registered stream multiplexer with round-robin arbitration and valid/ready handshake.

---
 rtl/multiplexor_n_in_arb.sv | 121 ++++++++++++
 1 files changed

// File: rtl/multiplexor_n_in_arb.sv
// N-input registered stream mux with round-robin arbitration and valid/ready handshake.
// Optional MUX_ARB_FORCE_SEL_EN adds force_en_i/force_sel_i to bypass the round-robin grant.
module multiplexor_n_in_arb #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned N_IN    = 4,
  localparam int unsigned NB_SEL = $clog2(N_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_IN*NB_DATA-1:0] data_i,
  input  logic [N_IN-1:0]         valid_i,
  output logic [N_IN-1:0]         ready_o,
  output logic [NB_DATA-1:0]      data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [NB_SEL-1:0]       sel_o
`ifdef MUX_ARB_FORCE_SEL_EN
  ,
  input  logic                    force_en_i,
  input  logic [NB_SEL-1:0]       force_sel_i
`endif
);

  localparam int unsigned NB_IDX = NB_SEL + 1;

  logic [NB_DATA-1:0] data_q, data_d;
  logic [NB_SEL-1:0]  sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [NB_SEL-1:0]  rr_ptr_q, rr_ptr_d;

  logic               load_en_c;
  logic               grant_vld_c;
  logic               forced_c;
  logic [NB_SEL-1:0]  grant_idx_c;
  logic [NB_DATA-1:0] grant_data_c;

  assign load_en_c = !valid_q || ready_i;

  // Round-robin search starting at rr_ptr; forced selection overrides when enabled.
  always_comb begin
    logic [NB_IDX-1:0] cand;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    forced_c    = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      cand = {1'b0, rr_ptr_q} + NB_IDX'(i);
      if (cand >= NB_IDX'(N_IN)) begin
        cand = cand - NB_IDX'(N_IN);
      end
      if (!grant_vld_c && valid_i[cand[NB_SEL-1:0]]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = cand[NB_SEL-1:0];
      end
    end
`ifdef MUX_ARB_FORCE_SEL_EN
    if (force_en_i) begin
      logic [NB_SEL-1:0] fsel;
      // Out-of-range selects fall back to channel 0, like the legacy mux.
      fsel        = (32'(force_sel_i) >= N_IN) ? '0 : force_sel_i;
      forced_c    = 1'b1;
      grant_idx_c = fsel;
      grant_vld_c = valid_i[fsel];
    end
`endif
  end

  // Data slice of the granted channel, decoded with constant part-selects.
  always_comb begin
    grant_data_c = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (grant_idx_c == NB_SEL'(k)) begin
        grant_data_c = data_i[k*NB_DATA +: NB_DATA];
      end
    end
  end

  always_comb begin
    ready_o = '0;
    if (rst_n_i && load_en_c && grant_vld_c) begin
      ready_o = N_IN'(1) << grant_idx_c;
    end
  end

  // Next-state for the output register and arbitration pointer.
  always_comb begin
    data_d   = data_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    if (load_en_c && grant_vld_c) begin
      data_d  = grant_data_c;
      sel_d   = grant_idx_c;
      valid_d = 1'b1;
      if (!forced_c) begin
        rr_ptr_d = (grant_idx_c == NB_SEL'(N_IN - 1)) ? '0 : grant_idx_c + NB_SEL'(1);
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q   <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      data_q   <= data_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign data_o  = data_q;
  assign sel_o   = sel_q;
  assign valid_o = valid_q;

endmodule
